// File: rtl/cyclotron_trace_serializer.sv
// Trace record FIFO that buffers multi-port register writeback records and
// serialises each one into a single beat per enabled writeback port.
module cyclotron_trace_serializer #(
    parameter int unsigned ARCH_LEN  = 32,
    parameter int unsigned NUM_WARPS = 8,
    parameter int unsigned NUM_LANES = 16,
    parameter int unsigned REG_BITS  = 8,
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned DEPTH     = 8,
    localparam int unsigned WID      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                                    clock,
    input  logic                                    reset,

    input  logic                                    trace_valid,
    output logic                                    trace_ready,
    input  logic [ARCH_LEN-1:0]                     trace_pc,
    input  logic [WID-1:0]                          trace_warpId,
    input  logic [NUM_LANES-1:0]                    trace_mask,
    input  logic [NUM_PORTS-1:0]                    trace_regs_enable,
    input  logic [NUM_PORTS*REG_BITS-1:0]           trace_regs_address,
    input  logic [NUM_PORTS*NUM_LANES*ARCH_LEN-1:0] trace_regs_data,

    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [ARCH_LEN-1:0]                     out_pc,
    output logic [WID-1:0]                          out_warpId,
    output logic [NUM_LANES-1:0]                    out_mask,
    output logic [2:0]                              out_port,
    output logic [REG_BITS-1:0]                     out_address,
    output logic [NUM_LANES*ARCH_LEN-1:0]           out_data,
    output logic                                    out_last,

    output logic                                    overflow,
    output logic [31:0]                             drop_count,
    output logic [31:0]                             beat_count,
    output logic                                    idle
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned DW = NUM_LANES * ARCH_LEN;
    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    // Payload storage; deliberately not reset, outputs are masked when empty.
    logic [ARCH_LEN-1:0]  pc_mem   [DEPTH];
    logic [WID-1:0]       warp_mem [DEPTH];
    logic [NUM_LANES-1:0] mask_mem [DEPTH];
    logic [NUM_PORTS-1:0] en_mem   [DEPTH];
    logic [REG_BITS-1:0]  addr_mem [DEPTH][NUM_PORTS];
    logic [DW-1:0]        data_mem [DEPTH][NUM_PORTS];

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [NUM_PORTS-1:0] pend_q, pend_d;
    logic                 overflow_q, overflow_d;
    logic [31:0]          drop_q, drop_d;
    logic [31:0]          beat_q, beat_d;

    logic                 push, pop, fire, drop, head_valid, last_beat;
    logic [AW-1:0]        rd_next;
    logic [NUM_PORTS-1:0] low_bit;
    logic [PW-1:0]        sel;

    assign trace_ready = (count_q < DepthCnt);
    assign head_valid  = (count_q != '0);
    assign push        = trace_valid && trace_ready && (|trace_regs_enable);
    assign drop        = trace_valid && !trace_ready;
    assign fire        = head_valid && out_ready;
    assign low_bit     = pend_q & (~pend_q + 1'b1);
    // Exactly one pending bit: clearing the lowest leaves nothing.
    assign last_beat   = head_valid && ((pend_q & ~low_bit) == '0);
    assign pop         = fire && last_beat;
    assign rd_next     = rd_ptr_q + 1'b1;

    always_comb begin
        sel = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (pend_q[k]) sel = PW'(k);
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pend_d     = pend_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        beat_d     = beat_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_next;
        end
        count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);

        if (fire) begin
            beat_d = beat_q + 32'd1;
            pend_d = pend_q & ~low_bit;
        end
        // Reload the pending mask whenever a new entry becomes the head.
        if (pop) begin
            if (count_q > (AW + 1)'(1)) begin
                pend_d = en_mem[rd_next];
            end else if (push) begin
                pend_d = trace_regs_enable;
            end else begin
                pend_d = '0;
            end
        end else if (!head_valid && push) begin
            pend_d = trace_regs_enable;
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            beat_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            beat_q     <= beat_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= trace_pc;
            warp_mem[wr_ptr_q] <= trace_warpId;
            mask_mem[wr_ptr_q] <= trace_mask;
            en_mem[wr_ptr_q]   <= trace_regs_enable;
            for (int k = 0; k < NUM_PORTS; k++) begin
                addr_mem[wr_ptr_q][k] <= trace_regs_address[k*REG_BITS +: REG_BITS];
                data_mem[wr_ptr_q][k] <= trace_regs_data[k*DW +: DW];
            end
        end
    end

    always_comb begin
        out_valid   = head_valid;
        out_last    = last_beat;
        out_pc      = '0;
        out_warpId  = '0;
        out_mask    = '0;
        out_port    = '0;
        out_address = '0;
        out_data    = '0;
        if (head_valid) begin
            out_pc      = pc_mem[rd_ptr_q];
            out_warpId  = warp_mem[rd_ptr_q];
            out_mask    = mask_mem[rd_ptr_q];
            out_port    = 3'(sel);
            out_address = addr_mem[rd_ptr_q][sel];
            out_data    = data_mem[rd_ptr_q][sel];
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign beat_count = beat_q;
    assign idle       = !head_valid;

endmodule

// File: tb/tb_cyclotron_trace_serializer.sv
// Directed bench for cyclotron_trace_serializer: reset, serialisation order,
// zero-enable discard, overflow, full push/pop, stalls and mid-record reset.
module tb_cyclotron_trace_serializer;

    localparam int ARCH_LEN  = 32;
    localparam int NUM_WARPS = 8;
    localparam int NUM_LANES = 16;
    localparam int REG_BITS  = 8;
    localparam int NUM_PORTS = 3;
    localparam int DEPTH     = 8;
    localparam int WID       = 3;
    localparam int DW        = NUM_LANES * ARCH_LEN;

    logic                          clock;
    logic                          reset;
    logic                          trace_valid;
    logic                          trace_ready;
    logic [ARCH_LEN-1:0]           trace_pc;
    logic [WID-1:0]                trace_warpId;
    logic [NUM_LANES-1:0]          trace_mask;
    logic [NUM_PORTS-1:0]          trace_regs_enable;
    logic [NUM_PORTS*REG_BITS-1:0] trace_regs_address;
    logic [NUM_PORTS*DW-1:0]       trace_regs_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [ARCH_LEN-1:0]           out_pc;
    logic [WID-1:0]                out_warpId;
    logic [NUM_LANES-1:0]          out_mask;
    logic [2:0]                    out_port;
    logic [REG_BITS-1:0]           out_address;
    logic [DW-1:0]                 out_data;
    logic                          out_last;
    logic                          overflow;
    logic [31:0]                   drop_count;
    logic [31:0]                   beat_count;
    logic                          idle;

    int checks   = 0;
    int failures = 0;

    cyclotron_trace_serializer #(
        .ARCH_LEN (ARCH_LEN),
        .NUM_WARPS(NUM_WARPS),
        .NUM_LANES(NUM_LANES),
        .REG_BITS (REG_BITS),
        .NUM_PORTS(NUM_PORTS),
        .DEPTH    (DEPTH)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .trace_valid       (trace_valid),
        .trace_ready       (trace_ready),
        .trace_pc          (trace_pc),
        .trace_warpId      (trace_warpId),
        .trace_mask        (trace_mask),
        .trace_regs_enable (trace_regs_enable),
        .trace_regs_address(trace_regs_address),
        .trace_regs_data   (trace_regs_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_warpId        (out_warpId),
        .out_mask          (out_mask),
        .out_port          (out_port),
        .out_address       (out_address),
        .out_data          (out_data),
        .out_last          (out_last),
        .overflow          (overflow),
        .drop_count        (drop_count),
        .beat_count        (beat_count),
        .idle              (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [ARCH_LEN-1:0] rec_pc(input int id);
        return 32'h1000 + 32'(id * 4);
    endfunction

    function automatic logic [REG_BITS-1:0] rec_addr(input int id, input int k);
        return 8'(id * 4 + k + 1);
    endfunction

    function automatic logic [DW-1:0] rec_data(input int id, input int k);
        logic [DW-1:0] r;
        for (int g = 0; g < NUM_LANES; g++) r[g*ARCH_LEN +: ARCH_LEN] = {8'(id), 8'(k), 16'(g)};
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_record(input int id, input logic [NUM_PORTS-1:0] en);
        trace_pc          = rec_pc(id);
        trace_warpId      = 3'(id % 8);
        trace_mask        = 16'hA5A5 ^ 16'(id);
        trace_regs_enable = en;
        for (int k = 0; k < NUM_PORTS; k++) begin
            trace_regs_address[k*REG_BITS +: REG_BITS] = rec_addr(id, k);
            trace_regs_data[k*DW +: DW]                = rec_data(id, k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        trace_valid = 1'b0;
        out_ready = 1'b0;
        set_record(0, 3'b000);
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (trace_ready !== 1'b1) begin failures++; $display("FAIL reset_trace_ready got=%0b exp=1", trace_ready); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%0b exp=1", idle); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%0b exp=0", out_last); end
        checks++; if (overflow !== 1'b0 || drop_count !== 32'd0 || beat_count !== 32'd0) begin
            failures++; $display("FAIL reset_status got ovf=%0b drop=%0d beat=%0d exp 0/0/0", overflow, drop_count, beat_count);
        end
        checks++; if (out_data !== '0 || out_address !== '0 || out_pc !== '0) begin
            failures++; $display("FAIL reset_payload got pc=%h addr=%h exp zero", out_pc, out_address);
        end
        #3 reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_record(1, 3'b101);
        trace_regs_address[0 +: REG_BITS]          = 8'd5;
        trace_regs_address[2*REG_BITS +: REG_BITS] = 8'd9;
        trace_valid = 1'b1;
        out_ready   = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_bypass got=%0b exp=0", out_valid); end
        tick();
        trace_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_port !== 3'd0 || out_address !== 8'd5 || out_last !== 1'b0) begin
            failures++; $display("FAIL single_beat0 got v=%0b port=%0d addr=%0d last=%0b exp 1/0/5/0", out_valid, out_port, out_address, out_last);
        end
        checks++; if (out_data !== rec_data(1, 0) || out_pc !== rec_pc(1) || out_mask !== (16'hA5A5 ^ 16'd1) || out_warpId !== 3'd1) begin
            failures++; $display("FAIL single_payload0 got pc=%h mask=%h warp=%0d", out_pc, out_mask, out_warpId);
        end
        tick();
        checks++; if (out_valid !== 1'b1 || out_port !== 3'd2 || out_address !== 8'd9 || out_last !== 1'b1) begin
            failures++; $display("FAIL single_beat1 got v=%0b port=%0d addr=%0d last=%0b exp 1/2/9/1", out_valid, out_port, out_address, out_last);
        end
        checks++; if (out_data !== rec_data(1, 2)) begin failures++; $display("FAIL single_data1 got=%h", out_data[31:0]); end
        tick();
        checks++; if (out_valid !== 1'b0 || idle !== 1'b1 || beat_count !== 32'd2) begin
            failures++; $display("FAIL single_done got v=%0b idle=%0b beats=%0d exp 0/1/2", out_valid, idle, beat_count);
        end
    endtask

    task automatic test_zero_enable();
        set_record(2, 3'b000);
        trace_valid = 1'b1;
        tick();
        trace_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || idle !== 1'b1 || trace_ready !== 1'b1) begin
            failures++; $display("FAIL zero_en_state got v=%0b idle=%0b rdy=%0b exp 0/1/1", out_valid, idle, trace_ready);
        end
        checks++; if (beat_count !== 32'd2 || drop_count !== 32'd0 || overflow !== 1'b0) begin
            failures++; $display("FAIL zero_en_counters got beat=%0d drop=%0d ovf=%0b exp 2/0/0", beat_count, drop_count, overflow);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_record(i, 3'b001);
            trace_valid = 1'b1;
            tick();
        end
        checks++; if (trace_ready !== 1'b0) begin failures++; $display("FAIL ovf_full_ready got=%0b exp=0", trace_ready); end
        set_record(8, 3'b001);
        tick();
        trace_valid = 1'b0;
        checks++; if (overflow !== 1'b1 || drop_count !== 32'd1) begin
            failures++; $display("FAIL ovf_drop got ovf=%0b drop=%0d exp 1/1", overflow, drop_count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== rec_pc(i) || out_last !== 1'b1 || out_address !== rec_addr(i, 0)) begin
                failures++; $display("FAIL ovf_drain%0d got v=%0b pc=%h last=%0b exp pc=%h", i, out_valid, out_pc, out_last, rec_pc(i));
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || beat_count !== 32'd10) begin
            failures++; $display("FAIL ovf_end got v=%0b beats=%0d exp 0/10", out_valid, beat_count);
        end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        for (int i = 10; i < 10 + DEPTH; i++) begin
            set_record(i, 3'b001);
            trace_valid = 1'b1;
            tick();
        end
        set_record(18, 3'b001);
        out_ready = 1'b1;
        #1;
        checks++; if (trace_ready !== 1'b0) begin failures++; $display("FAIL pushpop_ready got=%0b exp=0", trace_ready); end
        tick();
        trace_valid = 1'b0;
        checks++; if (drop_count !== 32'd2 || trace_ready !== 1'b1) begin
            failures++; $display("FAIL pushpop_after got drop=%0d rdy=%0b exp 2/1", drop_count, trace_ready);
        end
        for (int i = 11; i < 10 + DEPTH; i++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== rec_pc(i)) begin
                failures++; $display("FAIL pushpop_drain%0d got v=%0b pc=%h exp pc=%h", i, out_valid, out_pc, rec_pc(i));
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || idle !== 1'b1 || beat_count !== 32'd18) begin
            failures++; $display("FAIL pushpop_end got v=%0b idle=%0b beats=%0d exp 0/1/18", out_valid, idle, beat_count);
        end
    endtask

    task automatic test_stall();
        int k;
        int rec;
        int port;
        out_ready = 1'b0;
        set_record(20, 3'b111);
        trace_valid = 1'b1;
        tick();
        set_record(21, 3'b111);
        tick();
        trace_valid = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
            out_ready = cyc[0];
            #1;
            rec  = 20 + k / 3;
            port = k % 3;
            checks++;
            if (out_valid !== 1'b1 || out_port !== 3'(port) || out_address !== rec_addr(rec, port) ||
                out_data !== rec_data(rec, port) || out_pc !== rec_pc(rec) || out_last !== (port == 2)) begin
                failures++;
                $display("FAIL stall_beat%0d got v=%0b port=%0d addr=%0d last=%0b exp port=%0d addr=%0d",
                         k, out_valid, out_port, out_address, out_last, port, rec_addr(rec, port));
            end
            if (out_ready) k++;
            tick();
        end
        checks++; if (k !== 6) begin failures++; $display("FAIL stall_count got=%0d exp=6", k); end
        checks++; if (out_valid !== 1'b0 || beat_count !== 32'd24) begin
            failures++; $display("FAIL stall_end got v=%0b beats=%0d exp 0/24", out_valid, beat_count);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        set_record(30, 3'b111);
        trace_valid = 1'b1;
        tick();
        trace_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_port !== 3'd1 || beat_count !== 32'd25) begin
            failures++; $display("FAIL rstmid_pre got v=%0b port=%0d beats=%0d exp 1/1/25", out_valid, out_port, beat_count);
        end
        #1 reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || idle !== 1'b1 || out_last !== 1'b0) begin
            failures++; $display("FAIL rstmid_state got v=%0b idle=%0b last=%0b exp 0/1/0", out_valid, idle, out_last);
        end
        checks++; if (beat_count !== 32'd0 || drop_count !== 32'd0 || overflow !== 1'b0) begin
            failures++; $display("FAIL rstmid_counters got beat=%0d drop=%0d ovf=%0b exp 0", beat_count, drop_count, overflow);
        end
        #3 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin
                failures++; $display("FAIL rstmid_after%0d got v=%0b idle=%0b exp 0/1", i, out_valid, idle);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_enable();
        test_overflow();
        test_full_push_pop();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
